// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch block
package fetch_unit_pkg;

  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - imem, redirect/halt and decode handshake bundle of the fetch unit
interface fetch_if;

  logic [31:0] o_imem_pc;
  logic [31:0] i_imem_inst;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
  logic        o_busy;

  modport master (
    output o_imem_pc,
    input  i_imem_inst,
    input  i_redirect_valid,
    input  i_redirect_pc,
    input  i_halt,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    input  i_inst_ready,
    output o_busy
  );

  modport slave (
    input  o_imem_pc,
    output i_imem_inst,
    output i_redirect_valid,
    output i_redirect_pc,
    output i_halt,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    output i_inst_ready,
    input  o_busy
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - prefetch FIFO of {pc, inst} entries with wrap-bit pointers
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - imem fetch initiator: pc register, run/halt FSM, redirect and FIFO arbitration
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  fetch_if.master  bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop, full, empty;
  fetch_entry_t head;

  assign pop  = !empty && bus.i_inst_ready && !bus.i_redirect_valid;
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign push = (state_q == S_RUN) && !bus.i_halt && !bus.i_redirect_valid &&
                (!full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN:  if (bus.i_halt && !bus.i_redirect_valid) state_d = S_HALT;
      S_HALT: if (!bus.i_halt && !bus.i_redirect_valid) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (bus.i_redirect_valid) pc_d = bus.i_redirect_pc & ~32'd3;
    else if (push)            pc_d = pc_q + INST_BYTES;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (bus.i_redirect_valid),
    .i_data  ('{pc: pc_q, inst: bus.i_imem_inst}),
    .o_full  (full),
    .o_empty (empty),
    .o_head  (head)
  );

  assign bus.o_imem_pc    = pc_q;
  assign bus.o_inst_valid = !empty;
  assign bus.o_inst       = head.inst;
  assign bus.o_inst_pc    = head.pc;
  assign bus.o_busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a linear-stream reference model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic i_clk;
  logic i_rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  function automatic logic [31:0] imem_word(logic [31:0] pc);
    return 32'h13 + (pc >> 2);
  endfunction

  assign bus.i_imem_inst = imem_word(bus.o_imem_pc);

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: decode must see a gap-free pc stream, restarting at each redirect target.
  fetch_entry_t exp_q[$];
  logic [31:0]  next_pc;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: next_pc, inst: imem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      next_pc = 32'h0;
    end else begin
      chk("imem_pc_aligned", {30'd0, bus.o_imem_pc[1:0]}, 32'd0);
      if (bus.i_redirect_valid) begin
        exp_q.delete();
        next_pc = bus.i_redirect_pc & ~32'd3;
      end else if (bus.o_inst_valid) begin
        refill();
        chk("head_pc", bus.o_inst_pc, exp_q[0].pc);
        chk("head_inst", bus.o_inst, exp_q[0].inst);
        if (bus.i_inst_ready) void'(exp_q.pop_front());
      end else begin
        chk("empty_head_pc", bus.o_inst_pc, 32'd0);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic redirect_to(logic [31:0] tgt);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = tgt;
    cyc(1);
    bus.i_redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n              = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = 32'h0;
    bus.i_halt           = 1'b0;
    bus.i_inst_ready     = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_imem_pc", bus.o_imem_pc, 32'h0);
    chk("rst_inst", bus.o_inst, 32'h0);
    chk("rst_inst_pc", bus.o_inst_pc, 32'h0);
    cyc(2);
    i_rst_n = 1'b1;

    // Start-up latency and first three instructions
    cyc(1);
    chk("t1_valid_c1", {31'd0, bus.o_inst_valid}, 32'd0);
    chk("t1_busy_c1", {31'd0, bus.o_busy}, 32'd1);
    cyc(1);
    chk("t1_valid_c2", {31'd0, bus.o_inst_valid}, 32'd1);
    chk("t1_pc0", bus.o_inst_pc, 32'h0);
    chk("t1_inst0", bus.o_inst, 32'h13);
    cyc(1);
    chk("t1_pc1", bus.o_inst_pc, 32'h4);
    cyc(1);
    chk("t1_pc2", bus.o_inst_pc, 32'h8);

    // Back-pressure saturates the FIFO at 4 entries
    bus.i_inst_ready = 1'b0;
    redirect_to(32'h0);
    cyc(10);
    chk("t2_imem_pc_hold", bus.o_imem_pc, 32'h10);
    chk("t2_valid", {31'd0, bus.o_inst_valid}, 32'd1);
    chk("t2_head_pc", bus.o_inst_pc, 32'h0);
    bus.i_inst_ready = 1'b1;
    cyc(6);

    // Redirect with 3 queued entries
    bus.i_inst_ready = 1'b0;
    redirect_to(32'h200);
    cyc(3);
    chk("t3_imem_pc_pre", bus.o_imem_pc, 32'h20C);
    bus.i_inst_ready = 1'b1;
    redirect_to(32'h0000_0102);
    chk("t3_imem_pc", bus.o_imem_pc, 32'h100);
    chk("t3_flushed", {31'd0, bus.o_inst_valid}, 32'd0);
    cyc(1);
    chk("t3_valid", {31'd0, bus.o_inst_valid}, 32'd1);
    chk("t3_pc", bus.o_inst_pc, 32'h100);

    // Halt with 2 queued entries
    bus.i_inst_ready = 1'b0;
    redirect_to(32'h300);
    cyc(2);
    bus.i_halt       = 1'b1;
    bus.i_inst_ready = 1'b1;
    cyc(1);
    chk("t4_busy_halt", {31'd0, bus.o_busy}, 32'd0);
    chk("t4_pc_hold", bus.o_imem_pc, 32'h308);
    cyc(1);
    chk("t4_drained", {31'd0, bus.o_inst_valid}, 32'd0);
    cyc(3);
    chk("t4_still_empty", {31'd0, bus.o_inst_valid}, 32'd0);
    chk("t4_pc_hold2", bus.o_imem_pc, 32'h308);
    bus.i_halt = 1'b0;
    cyc(1);
    chk("t4_busy_resume", {31'd0, bus.o_busy}, 32'd1);
    cyc(1);
    chk("t4_resume_pc", bus.o_inst_pc, 32'h308);

    // pc wraps modulo 2^32
    redirect_to(32'hFFFF_FFF8);
    cyc(1);
    chk("t5_pc0", bus.o_inst_pc, 32'hFFFF_FFF8);
    cyc(1);
    chk("t5_pc1", bus.o_inst_pc, 32'hFFFF_FFFC);
    cyc(1);
    chk("t5_pc2", bus.o_inst_pc, 32'h0);

    // Randomized traffic; the scoreboard checks every presented head
    for (int i = 0; i < 400; i++) begin
      bus.i_inst_ready     = ($urandom_range(9) < 7);
      bus.i_redirect_valid = ($urandom_range(24) == 0);
      bus.i_redirect_pc    = $urandom;
      if ($urandom_range(9) == 0) bus.i_halt = !bus.i_halt;
      cyc(1);
    end
    bus.i_redirect_valid = 1'b0;
    bus.i_halt           = 1'b0;
    bus.i_inst_ready     = 1'b1;
    cyc(4);

    // Asynchronous reset mid-stream
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, bus.o_inst_valid}, 32'd0);
    chk("t6_imem_pc", bus.o_imem_pc, 32'h0);
    chk("t6_busy", {31'd0, bus.o_busy}, 32'd0);
    cyc(1);
    i_rst_n = 1'b1;
    cyc(1);
    chk("t6_valid_c1", {31'd0, bus.o_inst_valid}, 32'd0);
    cyc(1);
    chk("t6_valid_c2", {31'd0, bus.o_inst_valid}, 32'd1);
    chk("t6_pc0", bus.o_inst_pc, 32'h0);
    chk("t6_inst0", bus.o_inst, 32'h13);
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
